alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Front-end sequencer that sits directly upstream of the ALU core and replaces the direct switch-to-operand wiring. The user enters A, then B, then OP on four switches and confirms each with a single debounced push-button. The three values are committed to the ALU core together, and a one-cycle VALID pulse is issued. A 2-bit phase indication drives status LEDs, so the user always knows which value the next press will capture.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles (10 ms at 50 MHz) a synchronized button level must hold before it is accepted; legal range ≥ 1; counter width = $clog2(DEBOUNCE_CYCLES+1)
- CLOCK_50  input  1  system clock; all state updates on the rising edge
- RESET_N  input  1  asynchronous, active-low reset
- SW_DATA  input  4  operand/opcode entry switches; asynchronous, quasi-static
- STEP_N  input  1  confirm push-button; active-low, asynchronous, bouncing
- A_OUT  output  4  committed operand A to the ALU core
- B_OUT  output  4  committed operand B to the ALU core
- OP_OUT  output  2  committed opcode (SW_DATA[1:0]) to the ALU core
- VALID  output  1  one-cycle pulse when a new A/B/OP triple is committed
- PHASE  output  2  current FSM state encoding, for LEDs

## Operation
- Input conditioning:
  - STEP_N passes through a 2-FF synchronizer; the synchronizer output is `s`.
  - SW_DATA also passes through a 2-FF synchronizer; it is sampled only on press events.
- Debouncer:
  - Holds the accepted level `db` and a counter `cnt`.
  - If `s == db`: `cnt <= 0`.
  - Otherwise `cnt` increments each cycle.
  - When `s != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= s` and `cnt <= 0`.
  - Any bounce back to `s == db` before that point restarts the count.
- Press event: one-cycle internal pulse on a registered `db` falling edge (1→0). Release (0→1) is debounced identically but produces no event.
- FSM states and PHASE encoding:
  - LOAD_A = 00. On press: `a_stage <= SW_DATA`, go to LOAD_B.
  - LOAD_B = 01. On press: `b_stage <= SW_DATA`, go to LOAD_OP.
  - LOAD_OP = 10. On press: `A_OUT <= a_stage`, `B_OUT <= b_stage`, `OP_OUT <= SW_DATA[1:0]`, `VALID <= 1` for exactly one cycle, go to SHOW.
  - SHOW = 11. On press: go to LOAD_A, capture nothing.
- Commit rules:
  - Outputs change only on the LOAD_OP press, and all three update atomically in the same cycle.
  - Outputs hold their previous values throughout LOAD_A and LOAD_B, so the ALU keeps showing the last result while new operands are staged.
- Arithmetic: none. Values pass through at full width. SW_DATA[3:2] are ignored in LOAD_OP.
- Boundaries:
  - Holding the button down yields exactly one press event; no auto-repeat.
  - A press is always accepted in every state; there is no busy condition.
  - Switch changes between presses have no effect.
  - DEBOUNCE_CYCLES=1 accepts any level that is stable for one synchronized cycle.

## Timing
- Reset (RESET_N low, asynchronous assert, effective immediately):
  - A_OUT=0, B_OUT=0, OP_OUT=0, VALID=0, PHASE=00 (LOAD_A).
  - a_stage=0, b_stage=0, cnt=0.
  - Synchronizer FFs and `db` = 1 (released).
- Reset mid-entry discards staged values and returns to LOAD_A.
- Release of RESET_N is synchronous to CLOCK_50. The first press can be recognized no earlier than DEBOUNCE_CYCLES+3 edges after release.
- Press latency: with STEP_N first sampled low at edge 0 and held low:
  - `db` falls at edge DEBOUNCE_CYCLES+1.
  - The press event is registered at edge DEBOUNCE_CYCLES+2.
  - The FSM state, staged or committed registers, and VALID update at edge DEBOUNCE_CYCLES+3.
- VALID is high for exactly the one cycle after the commit edge. It is never high in consecutive cycles.
- SW_DATA must be stable for ≥ 2 cycles before the capture edge; guaranteed by the debounce interval for human input.

## Test plan
- Reset: assert RESET_N=0 mid-cycle with A_OUT=5 → all outputs 0 and PHASE=00 immediately, without waiting for a clock edge.
- Full entry (DEBOUNCE_CYCLES=4): clean presses with SW_DATA=0x3, then 0x9, then 0x2 → after the third press, A_OUT=3, B_OUT=9, OP_OUT=2, and VALID is high for 1 cycle at edge 7 relative to the third press. PHASE sequence: 00→01→10→11.
- Atomic commit: with A=3/B=9/OP=2 committed, press in SHOW, then enter 0xF and 0x1 → A_OUT, B_OUT and OP_OUT remain 3/9/2 and VALID stays 0 until the OP press.
- Bounce rejection (DEBOUNCE_CYCLES=4): STEP_N low for 3 cycles, high 1, low 3, high → no press event; PHASE unchanged. Then a low hold of 10 cycles → exactly one event.
- Held button: STEP_N low for 1000 cycles → one phase advance only. Release then press again → one further advance.
- Reset mid-entry: in LOAD_OP with b_stage=0xA, assert reset, then enter 0x1, 0x2, 0x3 → commit A=1, B=2, OP=3 with no residue of 0xA.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Operand entry sequencer for the ALU core: debounced step button walks
// A -> B -> OP -> SHOW and commits the A/B/OP triple atomically.
module alu_operand_loader #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [3:0] SW_DATA,
   input  logic       STEP_N,
   output logic [3:0] A_OUT,
   output logic [3:0] B_OUT,
   output logic [1:0] OP_OUT,
   output logic       VALID,
   output logic [1:0] PHASE
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOAD_A  = 2'b00,
      LOAD_B  = 2'b01,
      LOAD_OP = 2'b10,
      SHOW    = 2'b11
   } state_t;

   logic          step_s1_q;
   logic          step_s2_q;
   logic [3:0]    sw_s1_q;
   logic [3:0]    sw_s2_q;
   logic          db_q;
   logic          db_d;
   logic          db_dly_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   state_t        state_q;
   logic [3:0]    a_stage_q;
   logic [3:0]    b_stage_q;
   logic [3:0]    a_out_q;
   logic [3:0]    b_out_q;
   logic [1:0]    op_out_q;
   logic          valid_q;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         step_s1_q <= 1'b1;
         step_s2_q <= 1'b1;
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
      end else begin
         step_s1_q <= STEP_N;
         step_s2_q <= step_s1_q;
         sw_s1_q   <= SW_DATA;
         sw_s2_q   <= sw_s1_q;
      end
   end

   // Any return to the accepted level restarts the stability count.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (step_s2_q != db_q) begin
         if (cnt_q == CNT_MAX) begin
            db_d = step_s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q    <= '0;
         db_q     <= 1'b1;
         db_dly_q <= 1'b1;
         press_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         db_q     <= db_d;
         db_dly_q <= db_q;
         press_q  <= db_dly_q & ~db_q;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= LOAD_A;
         a_stage_q <= '0;
         b_stage_q <= '0;
         a_out_q   <= '0;
         b_out_q   <= '0;
         op_out_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (press_q) begin
            unique case (state_q)
               LOAD_A: begin
                  a_stage_q <= sw_s2_q;
                  state_q   <= LOAD_B;
               end
               LOAD_B: begin
                  b_stage_q <= sw_s2_q;
                  state_q   <= LOAD_OP;
               end
               LOAD_OP: begin
                  a_out_q  <= a_stage_q;
                  b_out_q  <= b_stage_q;
                  op_out_q <= sw_s2_q[1:0];
                  valid_q  <= 1'b1;
                  state_q  <= SHOW;
               end
               SHOW: begin
                  state_q <= LOAD_A;
               end
            endcase
         end
      end
   end

   assign A_OUT  = a_out_q;
   assign B_OUT  = b_out_q;
   assign OP_OUT = op_out_q;
   assign VALID  = valid_q;
   assign PHASE  = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader with a short debounce interval.
module tb_alu_operand_loader;

   localparam int D = 4;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
   } trip_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw = 4'h0;
   logic       step_n = 1'b1;
   logic [3:0] a_out;
   logic [3:0] b_out;
   logic [1:0] op_out;
   logic       valid;
   logic [1:0] phase;

   trip_t      sbq[$];
   int         checks = 0;
   int         passes = 0;
   logic [1:0] m_ph = 2'b00;
   logic [3:0] m_a = 4'h0;
   logic [3:0] m_b = 4'h0;
   trip_t      m_last = '0;
   logic       valid_prev = 1'b0;

   alu_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
      .CLOCK_50(clk),
      .RESET_N (rst_n),
      .SW_DATA (sw),
      .STEP_N  (step_n),
      .A_OUT   (a_out),
      .B_OUT   (b_out),
      .OP_OUT  (op_out),
      .VALID   (valid),
      .PHASE   (phase)
   );

   always #10 clk = ~clk;

   // Scoreboard consumer: every VALID pulse must match the oldest pending triple.
   always @(negedge clk) begin
      if (rst_n && valid) begin
         trip_t exp_t;
         checks++;
         if (valid_prev) begin
            $display("FAIL valid_consecutive: got 2 high cycles, want 1");
         end else begin
            passes++;
         end
         checks++;
         if (sbq.size() == 0) begin
            $display("FAIL valid_unexpected: got %h/%h/%h, want no commit",
                     a_out, b_out, op_out);
         end else begin
            exp_t = sbq.pop_front();
            if ({a_out, b_out, op_out} !== exp_t) begin
               $display("FAIL commit: got %h/%h/%h, want %h/%h/%h",
                        a_out, b_out, op_out, exp_t.a, exp_t.b, exp_t.op);
            end else begin
               passes++;
            end
         end
      end
      valid_prev = rst_n && valid;
   end

   task automatic model_press(input logic [3:0] v);
      case (m_ph)
         2'b00: m_a = v;
         2'b01: m_b = v;
         2'b10: begin
            m_last = '{a: m_a, b: m_b, op: v[1:0]};
            sbq.push_back(m_last);
         end
         default: ;
      endcase
      m_ph = m_ph + 2'b01;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      step_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_ph = 2'b00;
      m_a = '0;
      m_b = '0;
      m_last = '0;
      sbq.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] v, input int hold);
      @(negedge clk);
      sw = v;
      step_n = 1'b0;
      model_press(v);
      repeat (hold) @(negedge clk);
      step_n = 1'b1;
      repeat (D + 8) @(negedge clk);
      sw = 4'($urandom);
      checks++;
      if (phase !== m_ph) begin
         $display("FAIL phase_after_press: got %b, want %b", phase, m_ph);
      end else begin
         passes++;
      end
      checks++;
      if ({a_out, b_out, op_out} !== m_last) begin
         $display("FAIL outputs_hold: got %h/%h/%h, want %h/%h/%h",
                  a_out, b_out, op_out, m_last.a, m_last.b, m_last.op);
      end else begin
         passes++;
      end
   endtask

   task automatic check_drained(input string tag);
      checks++;
      if (sbq.size() != 0) begin
         $display("FAIL %s_pending: got %0d uncommitted, want 0", tag, sbq.size());
         sbq.delete();
      end else begin
         passes++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({a_out, b_out, op_out, valid, phase} !== 13'h0) begin
         $display("FAIL reset_state: got %h/%h/%h v=%b p=%b, want 0",
                  a_out, b_out, op_out, valid, phase);
      end else begin
         passes++;
      end
      press(4'h5, D + 8);
      press(4'h6, D + 8);
      press(4'h1, D + 8);
      checks++;
      if (a_out !== 4'h5) begin
         $display("FAIL reset_precond: got A=%h, want 5", a_out);
      end else begin
         passes++;
      end
      @(posedge clk);
      #5;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_out, b_out, op_out, valid, phase} !== 13'h0) begin
         $display("FAIL reset_async: got %h/%h/%h v=%b p=%b, want 0",
                  a_out, b_out, op_out, valid, phase);
      end else begin
         passes++;
      end
      do_reset();
   endtask

   task automatic test_full_entry();
      do_reset();
      press(4'h3, D + 8);
      press(4'h9, D + 8);
      @(negedge clk);
      sw = 4'h2;
      step_n = 1'b0;
      model_press(4'h2);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (valid !== (k == D + 3)) begin
            $display("FAIL valid_timing_edge%0d: got %b, want %b",
                     k, valid, k == D + 3);
         end else begin
            passes++;
         end
         checks++;
         if (phase !== ((k >= D + 3) ? 2'b11 : 2'b10)) begin
            $display("FAIL phase_timing_edge%0d: got %b, want %b",
                     k, phase, (k >= D + 3) ? 2'b11 : 2'b10);
         end else begin
            passes++;
         end
      end
      step_n = 1'b1;
      repeat (D + 8) @(negedge clk);
      checks++;
      if ({a_out, b_out, op_out} !== {4'h3, 4'h9, 2'h2}) begin
         $display("FAIL full_entry: got %h/%h/%h, want 3/9/2", a_out, b_out, op_out);
      end else begin
         passes++;
      end
      check_drained("full_entry");
   endtask

   task automatic test_atomic();
      press(4'h0, D + 8);
      press(4'hF, D + 8);
      press(4'h1, D + 8);
      checks++;
      if ({a_out, b_out, op_out, phase} !== {4'h3, 4'h9, 2'h2, 2'b10}) begin
         $display("FAIL atomic_hold: got %h/%h/%h p=%b, want 3/9/2 p=10",
                  a_out, b_out, op_out, phase);
      end else begin
         passes++;
      end
      press(4'hE, D + 8);
      check_drained("atomic");
   endtask

   task automatic test_bounce();
      logic [1:0] ph0;
      do_reset();
      ph0 = phase;
      @(negedge clk);
      step_n = 1'b0;
      repeat (3) @(negedge clk);
      step_n = 1'b1;
      @(negedge clk);
      step_n = 1'b0;
      repeat (3) @(negedge clk);
      step_n = 1'b1;
      repeat (D + 10) @(negedge clk);
      checks++;
      if (phase !== ph0) begin
         $display("FAIL bounce_reject: got %b, want %b", phase, ph0);
      end else begin
         passes++;
      end
      press(4'h7, 10);
   endtask

   task automatic test_held();
      press(4'h8, 1000);
      press(4'h4, D + 8);
   endtask

   task automatic test_reset_mid_entry();
      do_reset();
      press(4'h7, D + 8);
      press(4'hA, D + 8);
      do_reset();
      press(4'h1, D + 8);
      press(4'h2, D + 8);
      press(4'h3, D + 8);
      checks++;
      if ({a_out, b_out, op_out} !== {4'h1, 4'h2, 2'h3}) begin
         $display("FAIL reset_mid_entry: got %h/%h/%h, want 1/2/3",
                  a_out, b_out, op_out);
      end else begin
         passes++;
      end
      check_drained("reset_mid_entry");
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         press(4'($urandom), D + 2 + i);
         press(4'($urandom), D + 2 + i);
         press(4'($urandom), D + 2 + i);
         press(4'($urandom), D + 2 + i);
      end
      check_drained("back_to_back");
   endtask

   initial begin
      test_reset();
      test_full_entry();
      test_atomic();
      test_bounce();
      test_held();
      test_reset_mid_entry();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
